// File: rtl/fetch_seq_pkg.sv
// Shared constants for the fetch sequencer, instruction ROM and execute stage:
// opcode encodings, instruction field positions and the sequencer state type.
package fetch_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_OUT = 4'b0110;
   localparam logic [3:0] OP_JMP = 4'b0111;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam int unsigned FIELD_W    = 4;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned ADDR_LSB   = 8;
   localparam int unsigned AUX_LSB    = 4;
   localparam int unsigned INDEX_LSB  = 0;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StIssue = 2'd2,
      StHalt  = 2'd3
   } fetch_state_e;

   // Opcodes that are handed to the execute stage (everything else is consumed here).
   function automatic logic is_issued_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV) || (op == OP_OUT);
   endfunction

endpackage

// File: rtl/program_counter_reg.sv
// Program counter register: clear, load, increment with natural wrap, or hold.
module program_counter_reg #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_val,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else if (i_clear) begin
         r_pc <= '0;
      end else if (i_load) begin
         r_pc <= i_load_val;
      end else if (i_inc) begin
         r_pc <= r_pc + 1'b1;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetches instructions from the ROM, splits them into fields and issues them to the
// execute stage over valid/ready. Define FETCH_SEQ_JUMP_EN to make opcode 0111 a jump.
module instruction_fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  program_counter,
   input  logic [INSTR_W-1:0] instruction,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [3:0]         issue_opcode,
   output logic [3:0]         issue_addr,
   output logic [3:0]         issue_aux,
   output logic [3:0]         issue_index,
   output logic               busy,
   output logic               halted,
   output logic [7:0]         retired
);

   fetch_state_e r_state;
   logic         r_issue_valid;
   logic         r_busy;
   logic         r_halted;
   logic [7:0]   r_retired;
   logic [3:0]   r_opcode;
   logic [3:0]   r_addr;
   logic [3:0]   r_aux;
   logic [3:0]   r_index;

   logic [3:0]        w_op;
   logic              w_fetch;
   logic              w_transfer;
   logic              w_is_jmp;
   logic              w_is_hlt;
   logic              w_is_nop;
   logic              w_pc_clear;
   logic              w_pc_load;
   logic              w_pc_inc;
   logic [ADDR_W-1:0] w_jump_target;

   assign w_op          = instruction[OPCODE_LSB +: FIELD_W];
   assign w_fetch       = (r_state == StFetch);
   assign w_transfer    = (r_state == StIssue) && issue_ready;
   assign w_jump_target = ADDR_W'(instruction[INDEX_LSB +: FIELD_W]);
   assign w_is_hlt      = (w_op == OP_HLT);
`ifdef FETCH_SEQ_JUMP_EN
   assign w_is_jmp      = (w_op == OP_JMP);
`else
   assign w_is_jmp      = 1'b0;
`endif
   assign w_is_nop      = !is_issued_op(w_op) && !w_is_hlt && !w_is_jmp;

   // PC steps past an instruction either as it is consumed here (NOP) or when issued.
   assign w_pc_clear = (r_state == StHalt) && start;
   assign w_pc_load  = w_fetch && w_is_jmp;
   assign w_pc_inc   = (w_fetch && w_is_nop) || w_transfer;

   program_counter_reg #(
      .ADDR_W (ADDR_W)
   ) u_program_counter_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_pc_clear),
      .i_load     (w_pc_load),
      .i_load_val (w_jump_target),
      .i_inc      (w_pc_inc),
      .o_pc       (program_counter)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_issue_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_halted      <= 1'b0;
         r_retired     <= 8'd0;
         r_opcode      <= 4'd0;
         r_addr        <= 4'd0;
         r_aux         <= 4'd0;
         r_index       <= 4'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_state <= StFetch;
                  r_busy  <= 1'b1;
               end
            end
            StFetch: begin
               r_opcode <= w_op;
               r_addr   <= instruction[ADDR_LSB +: FIELD_W];
               r_aux    <= instruction[AUX_LSB +: FIELD_W];
               r_index  <= instruction[INDEX_LSB +: FIELD_W];
               if (w_is_hlt) begin
                  r_state  <= StHalt;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else if (!w_is_nop && !w_is_jmp) begin
                  r_state       <= StIssue;
                  r_issue_valid <= 1'b1;
               end
            end
            StIssue: begin
               if (issue_ready) begin
                  r_state       <= StFetch;
                  r_issue_valid <= 1'b0;
                  if (r_retired != 8'hFF) begin
                     r_retired <= r_retired + 8'd1;
                  end
               end
            end
            StHalt: begin
               if (start) begin
                  r_state  <= StFetch;
                  r_busy   <= 1'b1;
                  r_halted <= 1'b0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign issue_valid  = r_issue_valid;
   assign issue_opcode = r_opcode;
   assign issue_addr   = r_addr;
   assign issue_aux    = r_aux;
   assign issue_index  = r_index;
   assign busy         = r_busy;
   assign halted       = r_halted;
   assign retired      = r_retired;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Scoreboard bench: a program walker queues the expected issue stream, transfers pop it.
module tb_instruction_fetch_sequencer;
   import fetch_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        issue_ready = 1'b0;
   logic [3:0]  program_counter;
   logic [15:0] instruction;
   logic        issue_valid;
   logic [3:0]  issue_opcode, issue_addr, issue_aux, issue_index;
   logic        busy, halted;
   logic [7:0]  retired;

   logic [15:0] rom [16];
   assign instruction = rom[program_counter];

   always #5 clk = ~clk;

   instruction_fetch_sequencer #(
      .ADDR_W  (4),
      .INSTR_W (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .program_counter (program_counter),
      .instruction     (instruction),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .issue_opcode    (issue_opcode),
      .issue_addr      (issue_addr),
      .issue_aux       (issue_aux),
      .issue_index     (issue_index),
      .busy            (busy),
      .halted          (halted),
      .retired         (retired)
   );

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] addr;
      logic [3:0] aux;
      logic [3:0] idx;
      logic [3:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          ready_mode = 0;
   int          stall_cnt = 0;
   int          last_pushed = 0;
   logic [15:0] stall_snap;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Walk the ROM image the way the sequencer should, queueing each instruction it issues.
   task automatic model_push(input int max_issues);
      logic [3:0]  pc;
      logic [15:0] w;
      logic [3:0]  op;
      pc = 4'd0;
      last_pushed = 0;
      for (int s = 0; s < 2000 && last_pushed < max_issues; s++) begin
         w  = rom[pc];
         op = w[15:12];
         if (op == 4'hF) break;
`ifdef FETCH_SEQ_JUMP_EN
         if (op == 4'h7) begin
            pc = w[3:0];
            continue;
         end
`endif
         if (op == 4'h0 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
            exp_q.push_back({op, w[11:8], w[7:4], w[3:0], pc});
            last_pushed++;
         end
         pc = pc + 4'd1;
      end
   endtask

   task automatic step();
      exp_t e;
      @(negedge clk);
      case (ready_mode)
         1: begin
            if (issue_valid && issue_opcode == OP_DIV && stall_cnt < 5) begin
               issue_ready = 1'b0;
               if (stall_cnt == 0) begin
                  stall_snap = {issue_opcode, issue_addr, issue_aux, issue_index};
               end else begin
                  check_val("stall_fields", {issue_opcode, issue_addr, issue_aux, issue_index},
                            stall_snap);
               end
               check_val("stall_valid", issue_valid, 1);
               check_val("stall_pc", program_counter, 2);
               stall_cnt++;
            end else begin
               issue_ready = 1'b1;
            end
         end
         2: issue_ready = !(issue_valid && program_counter == 4'd3);
         default: issue_ready = 1'b1;
      endcase
      if (issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_issue", {issue_opcode, program_counter}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_val("opcode", issue_opcode, e.op);
            check_val("addr", issue_addr, e.addr);
            check_val("aux", issue_aux, e.aux);
            check_val("index", issue_index, e.idx);
            check_val("issue_pc", program_counter, e.pc);
         end
      end
   endtask

   task automatic run_to_halt(input int bound);
      for (int i = 0; i < bound && !halted; i++) step();
      check_val("halt_reached", halted, 1);
   endtask

   task automatic run_until_empty(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
      check_val("queue_drained", exp_q.size(), 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic load_prog_a();
      for (int i = 0; i < 16; i++) rom[i] = 16'hF000;
      rom[0] = 16'h0100;  // ADD a1
      rom[1] = 16'h4100;  // MUL a1
      rom[2] = 16'h5060;  // DIV aux6
      rom[3] = 16'h6001;  // OUT idx1
      rom[4] = 16'h0000;  // ADD
      rom[5] = 16'h6002;  // OUT idx2
      rom[6] = 16'hF000;  // HLT
   endtask

   initial begin
      load_prog_a();
      step();
      step();
      rst_n = 1'b1;
      step();
      check_val("rst_busy", busy, 0);
      check_val("rst_valid", issue_valid, 0);
      check_val("rst_halted", halted, 0);
      check_val("rst_pc", program_counter, 0);
      check_val("rst_retired", retired, 0);
      check_val("rst_fields", {issue_opcode, issue_addr, issue_aux, issue_index}, 0);

      // Program A with DIV backpressure, plus a start pulse while busy.
      ready_mode = 1;
      stall_cnt  = 0;
      model_push(100);
      pulse_start();
      check_val("lat_busy", busy, 1);
      check_val("lat_valid_n1", issue_valid, 0);
      step();
      check_val("lat_valid_n2", issue_valid, 1);
      pulse_start();
      run_to_halt(300);
      check_val("halt_pc", program_counter, 6);
      check_val("halt_retired", retired, 6);
      check_val("halt_queue", exp_q.size(), 0);
      check_val("stall_cycles", stall_cnt, 5);

      // Restart from HALT keeps the retired count.
      ready_mode = 0;
      model_push(100);
      pulse_start();
      check_val("restart_pc", program_counter, 0);
      check_val("restart_busy", busy, 1);
      check_val("restart_halted", halted, 0);
      check_val("restart_retired", retired, 6);
      run_to_halt(300);
      check_val("rerun_retired", retired, 12);
      check_val("rerun_queue", exp_q.size(), 0);

      // Reset while OUT at PC 3 is waiting for ready.
      ready_mode = 2;
      model_push(100);
      pulse_start();
      for (int i = 0; i < 100 && !(issue_valid && program_counter == 4'd3); i++) step();
      check_val("hold_at_pc3", {issue_valid, program_counter}, {1'b1, 4'd3});
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", issue_valid, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_pc", program_counter, 0);
      check_val("mid_rst_retired", retired, 0);
      check_val("mid_rst_fields", {issue_opcode, issue_addr, issue_aux, issue_index}, 0);
      exp_q.delete();
      ready_mode = 0;
      step();
      rst_n = 1'b1;
      step();
      check_val("post_rst_idle", {busy, halted, issue_valid}, 0);
      check_val("post_rst_pc", program_counter, 0);
      model_push(100);
      pulse_start();
      run_to_halt(300);
      check_val("post_rst_retired", retired, 6);

      // Wrap and saturation: straight-line ADDs, never halting.
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = {4'h0, 4'(i), 8'h00};
      model_push(270);
      pulse_start();
      run_until_empty(1200);
      step();
      check_val("sat_retired", retired, 255);

      // Opcode 0111 at address 2: jump to 0 when enabled, NOP otherwise.
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 16'hF000;
      rom[0] = 16'h0110;
      rom[1] = 16'h0220;
      rom[2] = 16'h7000;
      rom[3] = 16'h6003;
      model_push(6);
      pulse_start();
      run_until_empty(200);
      step();
      check_val("jmp_retired", retired, last_pushed);
`ifdef FETCH_SEQ_JUMP_EN
      check_val("jmp_pc", program_counter, 2);
`else
      check_val("jmp_pc", program_counter, 4);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

Control-side counterpart of the instruction ROM: owns the 4-bit program counter that addresses the ROM, captures the returned 16-bit instruction, splits it into fields and hands each one to the execute datapath (accumulator/ALU/output register) over a valid/ready handshake. It sits between the ROM and the execute stage and is the only driver of `program_counter`.

## Interface
- `ADDR_W`, 4: program counter width; ROM depth is 2^ADDR_W.
- `INSTR_W`, 16: instruction width.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins execution at address 0 from IDLE or HALT.
- `program_counter`  out  ADDR_W  ROM address.
- `instruction`  in  INSTR_W  ROM data, combinational from `program_counter`.
- `issue_valid`  out  1  decoded instruction available.
- `issue_ready`  in  1  execute stage accepts.
- `issue_opcode`  out  4  instruction[15:12].
- `issue_addr`  out  4  operand memory address, instruction[11:8].
- `issue_aux`  out  4  secondary operand field, instruction[7:4].
- `issue_index`  out  4  output-register index, instruction[3:0].
- `busy`  out  1  high in FETCH or ISSUE.
- `halted`  out  1  high in HALT.
- `retired`  out  8  count of accepted issues, saturating.

## Operation
- Opcodes: 0000 ADD, 0100 MUL, 0101 DIV, 0110 OUT, 0111 JMP, 1111 HLT; all others are NOP.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: PC=0. `start` → FETCH.
- FETCH: `program_counter` drives the ROM. At the clock edge the instruction is latched into the issue registers. Next state:
  - HLT → HALT.
  - NOP → FETCH, PC+1.
  - JMP (when enabled) → FETCH, PC=instruction[3:0].
  - Otherwise → ISSUE.
- ISSUE: `issue_valid`=1. The fields stay stable until `issue_valid && issue_ready`. On transfer: PC+1 (wraps 15→0), `retired`+1 (saturating at 255), → FETCH. Without ready, the block holds indefinitely.
- HALT: PC frozen. `start` → PC=0, `retired` is kept, → FETCH.
- `start` in FETCH or ISSUE is ignored.
- NOP, JMP and HLT never assert `issue_valid` and never count as retired.

## Timing
- Reset (async assert, sync release): state IDLE, PC 0, all issue fields 0, `issue_valid`/`busy`/`halted` 0, `retired` 0.
- Reset mid-issue drops `issue_valid` immediately. The in-flight instruction is lost.
- `start` at edge N → FETCH during cycle N+1 → `issue_valid` during cycle N+2.
- Throughput with `issue_ready` held high: one instruction per 2 cycles.
- A NOP or JMP costs 1 cycle.
- `issue_valid` is registered and never drops without a transfer, except on reset.
- PC wrap from 15 to 0 is silent; the program loops until HLT.

## Configuration
- `FETCH_SEQ_JUMP_EN` defined: opcode 0111 is an unconditional jump to instruction[3:0], with no issue.
- Undefined: 0111 is a NOP, and the PC always increments.

## Structure
- `fetch_seq_pkg` holds:
  - the opcode localparams (OP_ADD, OP_MUL, OP_DIV, OP_OUT, OP_JMP, OP_HLT);
  - the state typedef/encoding;
  - the field bit-position constants.
- The ROM and the execute stage import the same opcode constants.
- One sub-module, `program_counter_reg`, handles the PC register: load, increment with wrap, hold, and clear on reset.

## Test plan
- ROM {ADD a1, MUL a1, DIV a6, OUT idx1, ADD, OUT idx2, HLT}, ready=1, pulse `start`:
  - six issues with opcodes 0,4,5,6,0,6;
  - `issue_addr` 1,1,0,…; DIV `issue_aux`=6; OUT `issue_index` 1 then 2;
  - `halted`=1 at PC 6; `retired`=6.
- Backpressure: ready held low 5 cycles in ISSUE of DIV → `issue_valid` and all fields stable for 5 cycles, PC stays 2; transfer on the first ready=1 cycle.
- Wrap: 16 ADDs, no HLT, ready=1 → PC sequence 0..15,0,1…; `retired` saturates at 255 after 255 issues.
- Jump (macro on): word at addr 2 = 0111_0000_0000_0000 → PC goes 2→0, no issue for it. Macro off: treated as NOP, PC 2→3.
- `rst_n` pulsed low while `issue_valid`=1 at PC 3 → all outputs 0 in the same cycle; IDLE after release; `start` restarts at PC 0.
- `start` pulsed while busy → ignored. `start` in HALT → fetch resumes at PC 0 with `retired` retained.
